pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Parametrised next-PC generator and PC register for the fetch stage. It arbitrates NUM_REDIRECT prioritised redirect channels, such as EX mispredict fix, EX jalr, ID early jal and ID predicted-taken branch. It adds a return-address stack (RAS) for predicted returns and holds the PC while fetch is stalled. It sits between the ID/EX redirect logic and the instruction-memory address port.

## Interface
Parameters:
- INST_ADDR_WIDTH, 32, PC width
- NUM_REDIRECT, 4, number of redirect channels; channel 0 has the highest priority
- RAS_DEPTH, 4, number of RAS entries; must be a power of two and at least 2
- RESET_PC, 0, PC value loaded on reset

Ports (reset is asynchronous and active-high):
- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- redirect_valid  input  NUM_REDIRECT  per-channel redirect request
- redirect_pc  input  NUM_REDIRECT*INST_ADDR_WIDTH  channel i target in bits [i*W +: W]
- fetch_ready  input  1  IF accepts the current PC this cycle
- ras_push  input  1  call seen in ID; push ras_push_addr
- ras_push_addr  input  INST_ADDR_WIDTH  return address (call PC+4)
- ras_pop  input  1  return predicted in ID; redirect to RAS top
- pc  output  INST_ADDR_WIDTH  current fetch PC (registered)
- ras_empty  output  1  RAS holds no valid entries
- redirect_hit  output  1  registered; a channel redirect was applied last cycle
- redirect_id  output  clog2(NUM_REDIRECT) (minimum 1)  registered index of the winning channel

## Operation
Next-PC priority, evaluated combinationally each cycle:
1. Lowest-index channel i with redirect_valid[i]=1: next = redirect_pc[i].
2. Otherwise, ras_pop=1 and ras_empty=0: next = RAS top.
3. Otherwise, fetch_ready=1: next = pc + 4, truncated mod 2^INST_ADDR_WIDTH (wrap from all-ones-minus-3 to 0).
4. Otherwise: next = pc (hold).

Stall and redirect rules:
- Redirects and RAS pops apply regardless of fetch_ready. A stalled fetch still observes a redirect, because the PC changes and the wrong-path fetch is discarded upstream.
- If any redirect_valid bit is set, ras_push and ras_pop are both ignored, since the ID instruction is being flushed.

RAS structure:
- Circular buffer of RAS_DEPTH entries with a top pointer and a count in the range 0..RAS_DEPTH.

RAS operations (only when no redirect is active):
- Push only: pointer advances mod RAS_DEPTH and the entry is written. Count saturates at RAS_DEPTH; on overflow the oldest entry is silently overwritten.
- Pop only, count > 0: top is used as the next PC, the pointer retreats mod RAS_DEPTH and the count decrements.
- Pop only, count = 0: no effect; falls through to rule 3 or 4.
- Push and pop together, count > 0: the next PC is the old top, the top entry is overwritten with ras_push_addr, and pointer and count are unchanged.
- Push and pop together, count = 0: behaves as push only, and the next PC is chosen by rule 3 or 4.

Outputs:
- ras_empty = (count == 0).

## Timing
- Reset values: pc = RESET_PC, count = 0, pointer = 0, ras_empty = 1, redirect_hit = 0, redirect_id = 0. RAS entry contents are don't-care.
- Asserting rst mid-operation clears everything immediately, independent of clk.
- Latency: a redirect asserted in cycle N appears on pc in cycle N+1. redirect_hit and redirect_id are valid in that same cycle N+1.
- RAS push and pop take effect at the same edge as the PC update. A pop in the cycle after a push returns the pushed address.
- There is no combinational path from any input to pc.

## Test plan
- Reset release with fetch_ready=1 held: pc reads 0x0, 0x4, 0x8 on successive cycles. With fetch_ready=0, pc holds 0x8.
- redirect_valid=4'b1010, channel 1 = 0x100, channel 3 = 0x200: next pc = 0x100, redirect_id = 1, redirect_hit = 1.
- Push 0x40, then pop: pc = 0x40 and ras_empty returns to 1. A second pop with fetch_ready=1 gives pc+4.
- With RAS_DEPTH=4, push 0x10, 0x20, 0x30, 0x40, 0x50, then pop five times. Pops return 0x50, 0x40, 0x30, 0x20; the fifth pop falls through to pc+4 with ras_empty=1.
- Pop with channel 0 active at 0x300 in the same cycle: pc = 0x300 and the RAS count is unchanged. Simultaneous push and pop with top 0x80 and push 0x90: pc = 0x80 and the new top is 0x90.
- pc = 0xFFFFFFFC with fetch_ready=1: next pc = 0x0. Assert rst mid-stream: pc becomes RESET_PC immediately, and ras_empty = 1.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with prioritised redirects and a return-address stack
module pc_redirect_unit #(
  parameter int INST_ADDR_WIDTH = 32,
  parameter int NUM_REDIRECT = 4,
  parameter int RAS_DEPTH = 4,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_REDIRECT-1:0] redirect_valid,
  input  logic [NUM_REDIRECT*INST_ADDR_WIDTH-1:0] redirect_pc,
  input  logic fetch_ready,
  input  logic ras_push,
  input  logic [INST_ADDR_WIDTH-1:0] ras_push_addr,
  input  logic ras_pop,
  output logic [INST_ADDR_WIDTH-1:0] pc,
  output logic ras_empty,
  output logic redirect_hit,
  output logic [(NUM_REDIRECT > 1 ? $clog2(NUM_REDIRECT) : 1)-1:0] redirect_id
);
  localparam int IDW = NUM_REDIRECT > 1 ? $clog2(NUM_REDIRECT) : 1;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d, sel_pc;
  logic [IDW-1:0] id_q, sel_id;
  logic hit_q, any_redirect, do_push, do_pop;
  logic [PW-1:0] ptr_q, ptr_d, wr_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [INST_ADDR_WIDTH-1:0] stack_q [RAS_DEPTH];
  // lowest-index valid channel wins, so scan from the top down and let lower indices overwrite
  always_comb begin
    sel_pc = '0;
    sel_id = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--)
      if (redirect_valid[i]) begin
        sel_pc = redirect_pc[i*INST_ADDR_WIDTH +: INST_ADDR_WIDTH];
        sel_id = IDW'(i);
      end
  end
  assign any_redirect = |redirect_valid;
  assign ras_empty = cnt_q == '0;
  assign do_push = !any_redirect && ras_push;
  assign do_pop = !any_redirect && ras_pop && !ras_empty;
  // a paired push+pop replaces the top in place; otherwise a push goes one slot above the top
  assign wr_idx = do_pop ? ptr_q : ptr_q + 1'b1;
  // next PC priority and RAS pointer/count bookkeeping
  always_comb begin
    pc_d = any_redirect ? sel_pc : do_pop ? stack_q[ptr_q] : fetch_ready ? pc_q + INST_ADDR_WIDTH'(4) : pc_q;
    ptr_d = (do_push && !do_pop) ? ptr_q + 1'b1 : (do_pop && !do_push) ? ptr_q - 1'b1 : ptr_q;
    cnt_d = (do_push && !do_pop) ? (cnt_q == FULL ? cnt_q : cnt_q + 1'b1) : (do_pop && !do_push) ? cnt_q - 1'b1 : cnt_q;
  end
  // architectural state with asynchronous reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
      id_q <= '0;
    end else begin
      pc_q <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      hit_q <= any_redirect;
      id_q <= sel_id;
    end
  // RAS storage needs no reset since count gates every read
  always_ff @(posedge clk)
    if (do_push) stack_q[wr_idx] <= ras_push_addr;
  assign pc = pc_q;
  assign redirect_hit = hit_q;
  assign redirect_id = id_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed scenario checks of the fetch PC / redirect / RAS block
module tb_pc_redirect_unit;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] redirect_valid;
  logic [127:0] redirect_pc;
  logic fetch_ready;
  logic ras_push;
  logic [31:0] ras_push_addr;
  logic ras_pop;
  logic [31:0] pc;
  logic ras_empty;
  logic redirect_hit;
  logic [1:0] redirect_id;
  int vectors = 0;
  int miscompares = 0;

  pc_redirect_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_ready(fetch_ready), .ras_push(ras_push), .ras_push_addr(ras_push_addr),
    .ras_pop(ras_pop), .pc(pc), .ras_empty(ras_empty), .redirect_hit(redirect_hit),
    .redirect_id(redirect_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = '0;
    redirect_pc = '0;
    fetch_ready = 1'b1;
    ras_push = 1'b0;
    ras_push_addr = '0;
    ras_pop = 1'b0;
    #2;
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", ras_empty); end
    vectors++; if (redirect_hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit got %b want 0", redirect_hit); end
    vectors++; if (redirect_id !== 2'd0) begin miscompares++; $display("FAIL reset_id got %0d want 0", redirect_id); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rel_pc0 got %h want %h", pc, 32'h0); end
    tick();
    vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL rel_pc4 got %h want %h", pc, 32'h4); end
    tick();
    vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL rel_pc8 got %h want %h", pc, 32'h8); end
    fetch_ready = 1'b0;
    tick();
    tick();
    vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL stall_hold got %h want %h", pc, 32'h8); end
  endtask

  task automatic test_redirect();
    redirect_valid = 4'b1010;
    redirect_pc = {32'h200, 32'h0, 32'h100, 32'h0};
    tick();
    vectors++; if (pc !== 32'h100) begin miscompares++; $display("FAIL redir_prio_pc got %h want %h", pc, 32'h100); end
    vectors++; if (redirect_hit !== 1'b1) begin miscompares++; $display("FAIL redir_hit got %b want 1", redirect_hit); end
    vectors++; if (redirect_id !== 2'd1) begin miscompares++; $display("FAIL redir_id got %0d want 1", redirect_id); end
    redirect_valid = 4'b1000;
    tick();
    vectors++; if (pc !== 32'h200) begin miscompares++; $display("FAIL redir_ch3_pc got %h want %h", pc, 32'h200); end
    vectors++; if (redirect_id !== 2'd3) begin miscompares++; $display("FAIL redir_ch3_id got %0d want 3", redirect_id); end
    redirect_valid = 4'b0000;
    fetch_ready = 1'b1;
    tick();
    vectors++; if (pc !== 32'h204) begin miscompares++; $display("FAIL redir_after_pc got %h want %h", pc, 32'h204); end
    vectors++; if (redirect_hit !== 1'b0) begin miscompares++; $display("FAIL redir_after_hit got %b want 0", redirect_hit); end
  endtask

  task automatic test_ras_single();
    ras_push = 1'b1;
    ras_push_addr = 32'h40;
    tick();
    vectors++; if (ras_empty !== 1'b0) begin miscompares++; $display("FAIL push1_empty got %b want 0", ras_empty); end
    ras_push = 1'b0;
    ras_pop = 1'b1;
    tick();
    vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL pop1_pc got %h want %h", pc, 32'h40); end
    vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL pop1_empty got %b want 1", ras_empty); end
    tick();
    vectors++; if (pc !== 32'h44) begin miscompares++; $display("FAIL pop_empty_pc got %h want %h", pc, 32'h44); end
    ras_pop = 1'b0;
  endtask

  task automatic test_ras_overflow();
    logic [31:0] want [5];
    want = '{32'h50, 32'h40, 32'h30, 32'h20, 32'h24};
    ras_push = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      ras_push_addr = 32'(k * 16);
      tick();
    end
    ras_push = 1'b0;
    ras_pop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++; if (pc !== want[k]) begin miscompares++; $display("FAIL ovf_pop%0d got %h want %h", k, pc, want[k]); end
    end
    vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL ovf_empty got %b want 1", ras_empty); end
    ras_pop = 1'b0;
  endtask

  task automatic test_pop_with_redirect();
    ras_push = 1'b1;
    ras_push_addr = 32'h60;
    tick();
    ras_push = 1'b0;
    ras_pop = 1'b1;
    redirect_valid = 4'b0001;
    redirect_pc = {32'h0, 32'h0, 32'h0, 32'h300};
    tick();
    vectors++; if (pc !== 32'h300) begin miscompares++; $display("FAIL poprd_pc got %h want %h", pc, 32'h300); end
    vectors++; if (ras_empty !== 1'b0) begin miscompares++; $display("FAIL poprd_empty got %b want 0", ras_empty); end
    redirect_valid = 4'b0000;
    tick();
    vectors++; if (pc !== 32'h60) begin miscompares++; $display("FAIL poprd_after got %h want %h", pc, 32'h60); end
    ras_pop = 1'b0;
    ras_push = 1'b1;
    ras_push_addr = 32'h70;
    redirect_valid = 4'b0001;
    tick();
    vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL pushrd_empty got %b want 1", ras_empty); end
    ras_push = 1'b0;
    redirect_valid = 4'b0000;
  endtask

  task automatic test_push_pop();
    ras_push = 1'b1;
    ras_push_addr = 32'h80;
    tick();
    ras_push_addr = 32'h90;
    ras_pop = 1'b1;
    tick();
    vectors++; if (pc !== 32'h80) begin miscompares++; $display("FAIL pp_pc got %h want %h", pc, 32'h80); end
    vectors++; if (ras_empty !== 1'b0) begin miscompares++; $display("FAIL pp_empty got %b want 0", ras_empty); end
    ras_push = 1'b0;
    tick();
    vectors++; if (pc !== 32'h90) begin miscompares++; $display("FAIL pp_newtop got %h want %h", pc, 32'h90); end
    vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL pp_drain got %b want 1", ras_empty); end
    ras_push = 1'b1;
    ras_push_addr = 32'ha0;
    tick();
    vectors++; if (pc !== 32'h94) begin miscompares++; $display("FAIL pp0_pc got %h want %h", pc, 32'h94); end
    vectors++; if (ras_empty !== 1'b0) begin miscompares++; $display("FAIL pp0_empty got %b want 0", ras_empty); end
    ras_push = 1'b0;
    tick();
    vectors++; if (pc !== 32'ha0) begin miscompares++; $display("FAIL pp0_pop got %h want %h", pc, 32'ha0); end
    ras_pop = 1'b0;
  endtask

  task automatic test_wrap_and_async_reset();
    redirect_valid = 4'b0100;
    redirect_pc = {32'h0, 32'hffff_fffc, 32'h0, 32'h0};
    tick();
    vectors++; if (pc !== 32'hffff_fffc) begin miscompares++; $display("FAIL wrap_set got %h want %h", pc, 32'hffff_fffc); end
    redirect_valid = 4'b0000;
    ras_push = 1'b1;
    ras_push_addr = 32'hb0;
    tick();
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %h want %h", pc, 32'h0); end
    ras_push = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL async_pc got %h want %h", pc, 32'h0); end
    vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL async_empty got %b want 1", ras_empty); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL post_reset got %h want %h", pc, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_ras_single();
    test_ras_overflow();
    test_pop_with_redirect();
    test_push_pop();
    test_wrap_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
